// File: rtl/vfree_list.sv
// Vector physical register free list.
// Holds the physical tags not currently mapped by the vector RAT as a FIFO. The
// rename stage pops the head on a grant and commit pushes retired tags back at
// the tail. A one-bit-per-tag bitmap tracks list membership so a tag that is
// already free cannot be released a second time. Overflowing releases and
// double releases are dropped and latch a sticky error flag.
//
// Handshake: alloc_gnt_o = alloc_req_i & ~empty_o in the same cycle, and
// alloc_tag_o is valid whenever the list is not empty. A granted tag leaves the
// list at the next clock edge. There is no release handshake: the list takes
// each legal release at the clock edge, and it flags every illegal release
// through error_o.
module vfree_list #(
    parameter int PHYS_REGS = 64,
    parameter int ARCH_REGS = 32,
    parameter int TAG_W     = $clog2(PHYS_REGS),
    parameter int DEPTH     = PHYS_REGS - ARCH_REGS
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             reconfigure_i,
    input  logic             alloc_req_i,
    output logic             alloc_gnt_o,
    output logic [TAG_W-1:0] alloc_tag_o,
    input  logic             release_valid_i,
    input  logic [TAG_W-1:0] release_tag_i,
    output logic [TAG_W:0]   free_count_o,
    output logic             empty_o,
    output logic             full_o,
    output logic             error_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = TAG_W + 1;

    logic [TAG_W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [CNT_W-1:0]     r_count;
    logic [PHYS_REGS-1:0] r_bitmap;
    logic                 r_error;

    logic                 w_empty;
    logic                 w_full;
    logic                 w_gnt;
    logic [TAG_W-1:0]     w_head_tag;
    logic                 w_rel_ok;
    logic                 w_rel_bad;

    // Pointer advance with an explicit wrap, because DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    // Flags decode the registered count only. The grant is the only output that depends on an input.
    always_comb begin
        w_empty    = (r_count == '0);
        w_full     = (r_count == CNT_W'(DEPTH));
        w_gnt      = alloc_req_i & ~w_empty;
        w_head_tag = r_mem[r_rd_ptr];
        // When the list is full, a release fits only if a grant frees a slot in the same cycle.
        // A tag granted in this cycle still has its bitmap bit set, so releasing that tag is rejected.
        w_rel_ok   = release_valid_i & ~r_bitmap[release_tag_i] & (~w_full | w_gnt);
        w_rel_bad  = release_valid_i & ~w_rel_ok;
    end

    assign alloc_gnt_o  = w_gnt;
    assign alloc_tag_o  = w_head_tag;
    assign free_count_o = r_count;
    assign empty_o      = w_empty;
    assign full_o       = w_full;
    assign error_o      = r_error;

    // Tag storage: reset fills the list with every non-architectural tag in ascending order.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_mem[k] <= TAG_W'(ARCH_REGS + k);
            end
        end else if (reconfigure_i) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_mem[k] <= TAG_W'(ARCH_REGS + k);
            end
        end else if (w_rel_ok) begin
            r_mem[r_wr_ptr] <= release_tag_i;
        end
    end

    // Read and write pointers. A grant moves the read pointer and a legal release moves the write pointer.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else if (reconfigure_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else begin
            if (w_gnt) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            if (w_rel_ok) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
        end
    end

    // Occupancy count: a grant and a legal release in the same cycle cancel out.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_count <= CNT_W'(DEPTH);
        end else if (reconfigure_i) begin
            r_count <= CNT_W'(DEPTH);
        end else begin
            case ({w_rel_ok, w_gnt})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Membership bitmap. A granted tag and a legally released tag are always different tags.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int t = 0; t < PHYS_REGS; t++) begin
                r_bitmap[t] <= (t >= ARCH_REGS);
            end
        end else if (reconfigure_i) begin
            for (int t = 0; t < PHYS_REGS; t++) begin
                r_bitmap[t] <= (t >= ARCH_REGS);
            end
        end else begin
            if (w_gnt) begin
                r_bitmap[w_head_tag] <= 1'b0;
            end
            if (w_rel_ok) begin
                r_bitmap[release_tag_i] <= 1'b1;
            end
        end
    end

    // Sticky error flag for a dropped release. Only reset or reconfigure clears it.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_error <= 1'b0;
        end else if (reconfigure_i) begin
            r_error <= 1'b0;
        end else if (w_rel_bad) begin
            r_error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_vfree_list.sv
// Testbench for vfree_list. A queue-of-free-tags reference model predicts each
// cycle's outputs. A monitor checks the status flags every cycle and checks the
// granted tags against a FIFO of expected tags.
module tb_vfree_list;

  localparam int PHYS_REGS = 64;
  localparam int ARCH_REGS = 32;
  localparam int TAG_W     = 6;
  localparam int DEPTH     = PHYS_REGS - ARCH_REGS;

  typedef struct packed {
    logic           gnt;
    logic [TAG_W:0] cnt;
    logic           empty;
    logic           full;
    logic           err;
  } exp_t;

  logic             clk_i;
  logic             rstn_i;
  logic             reconfigure_i;
  logic             alloc_req_i;
  logic             alloc_gnt_o;
  logic [TAG_W-1:0] alloc_tag_o;
  logic             release_valid_i;
  logic [TAG_W-1:0] release_tag_i;
  logic [TAG_W:0]   free_count_o;
  logic             empty_o;
  logic             full_o;
  logic             error_o;

  // scoreboard queues
  logic [TAG_W-1:0] exp_q[$];
  exp_t             st_q[$];

  // reference model: the free tags in FIFO order, list membership, and the sticky error
  logic [TAG_W-1:0]     model_q[$];
  bit [PHYS_REGS-1:0]   in_list;
  bit                   m_err;
  logic [TAG_W-1:0]     held[$];

  int n_cmp  = 0;
  int n_fail = 0;

  vfree_list #(
    .PHYS_REGS(PHYS_REGS),
    .ARCH_REGS(ARCH_REGS),
    .TAG_W(TAG_W),
    .DEPTH(DEPTH)
  ) dut (
    .clk_i(clk_i),
    .rstn_i(rstn_i),
    .reconfigure_i(reconfigure_i),
    .alloc_req_i(alloc_req_i),
    .alloc_gnt_o(alloc_gnt_o),
    .alloc_tag_o(alloc_tag_o),
    .release_valid_i(release_valid_i),
    .release_tag_i(release_tag_i),
    .free_count_o(free_count_o),
    .empty_o(empty_o),
    .full_o(full_o),
    .error_o(error_o)
  );

  // clock / reset
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: sim time limit reached, expected finish earlier");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    model_q.delete();
    for (int k = 0; k < DEPTH; k++) model_q.push_back(TAG_W'(ARCH_REGS + k));
    for (int t = 0; t < PHYS_REGS; t++) in_list[t] = (t >= ARCH_REGS);
    m_err = 1'b0;
    held.delete();
  endtask

  // driver: one clock cycle of stimulus. It predicts that cycle's outputs and then advances the model.
  task automatic cycle(input bit req, input bit rv, input logic [TAG_W-1:0] rtag, input bit rc);
    exp_t e;
    bit legal;
    int sz;
    logic [TAG_W-1:0] t;
    int idx[$];
    @(posedge clk_i);
    #1;
    alloc_req_i     = req;
    release_valid_i = rv;
    release_tag_i   = rtag;
    reconfigure_i   = rc;
    sz      = model_q.size();
    e.cnt   = (TAG_W+1)'(sz);
    e.empty = (sz == 0);
    e.full  = (sz == DEPTH);
    e.err   = m_err;
    e.gnt   = req && (sz > 0);
    st_q.push_back(e);
    if (e.gnt) exp_q.push_back(model_q[0]);
    if (rc) begin
      model_reset();
    end else begin
      legal = rv && !in_list[rtag] && ((sz < DEPTH) || e.gnt);
      if (e.gnt) begin
        t = model_q.pop_front();
        in_list[t] = 1'b0;
        held.push_back(t);
      end
      if (legal) begin
        model_q.push_back(rtag);
        in_list[rtag] = 1'b1;
        idx = held.find_first_index(x) with (x == rtag);
        if (idx.size() > 0) held.delete(idx[0]);
      end else if (rv) begin
        m_err = 1'b1;
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk_i);
    #1;
    rstn_i          = 1'b0;
    alloc_req_i     = 1'b0;
    release_valid_i = 1'b0;
    release_tag_i   = '0;
    reconfigure_i   = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    rstn_i = 1'b1;
  endtask

  // monitor: checks status every cycle and the tag on each grant
  initial begin
    exp_t e;
    logic [TAG_W-1:0] t;
    forever begin
      @(negedge clk_i);
      if (st_q.size() > 0) begin
        e = st_q.pop_front();
        chk("gnt",   alloc_gnt_o,  e.gnt);
        chk("count", free_count_o, e.cnt);
        chk("empty", empty_o,      e.empty);
        chk("full",  full_o,       e.full);
        chk("error", error_o,      e.err);
        if (alloc_gnt_o) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_grant", 1, 0);
          end else begin
            t = exp_q.pop_front();
            chk("alloc_tag", alloc_tag_o, t);
          end
        end
      end
    end
  end

  // stimulus
  initial begin
    logic [TAG_W-1:0] rtag;
    int p_req, p_rel, r;
    bit req, rv, rc;
    rstn_i          = 1'b0;
    alloc_req_i     = 1'b0;
    release_valid_i = 1'b0;
    release_tag_i   = '0;
    reconfigure_i   = 1'b0;
    model_reset();
    repeat (3) @(posedge clk_i);
    #1;
    rstn_i = 1'b1;

    // drain the list: 32 grants of tags 32..63, then a cycle with the list empty
    repeat (33) cycle(1, 0, '0, 0);
    // release into the empty list: no bypass, so the tag is granted one cycle later
    cycle(1, 1, TAG_W'(40), 0);
    cycle(1, 0, '0, 0);
    cycle(0, 0, '0, 0);

    // a release into the full list overflows and is dropped
    do_reset();
    cycle(0, 1, TAG_W'(5), 0);
    cycle(0, 0, '0, 0);

    // second release of the same tag is a double release
    do_reset();
    cycle(1, 0, '0, 0);
    cycle(0, 1, TAG_W'(32), 0);
    cycle(0, 1, TAG_W'(32), 0);
    cycle(0, 0, '0, 0);

    // same-tag hazard: release the head tag in the cycle it is granted
    do_reset();
    cycle(1, 1, TAG_W'(32), 0);
    cycle(0, 0, '0, 0);

    // steady state: allocate and release together for 100 cycles
    do_reset();
    repeat (4) cycle(1, 0, '0, 0);
    for (int i = 0; i < 100; i++) cycle(1, 1, held[0], 0);
    cycle(0, 0, '0, 0);

    // reconfigure while count=7 and error_o=1; the release and alloc in that cycle are ignored
    do_reset();
    repeat (25) cycle(1, 0, '0, 0);
    cycle(0, 1, TAG_W'(60), 0);
    cycle(1, 1, TAG_W'(32), 1);
    cycle(1, 0, '0, 0);
    cycle(0, 0, '0, 0);

    // randomized phases with varying allocate and release pressure
    for (int ph = 0; ph < 12; ph++) begin
      p_req = $urandom_range(1, 9);
      p_rel = $urandom_range(1, 9);
      for (int i = 0; i < 200; i++) begin
        r = $urandom_range(0, 999);
        if (r == 0) begin
          do_reset();
        end else begin
          rc  = (r < 4);
          req = ($urandom_range(0, 9) < p_req);
          rv  = ($urandom_range(0, 9) < p_rel);
          if (held.size() > 0 && $urandom_range(0, 3) != 0)
            rtag = held[$urandom_range(0, held.size() - 1)];
          else
            rtag = TAG_W'($urandom_range(0, PHYS_REGS - 1));
          cycle(req, rv, rtag, rc);
        end
      end
    end

    @(posedge clk_i);
    #1;
    alloc_req_i     = 1'b0;
    release_valid_i = 1'b0;
    reconfigure_i   = 1'b0;
    @(negedge clk_i);
    #1;
    chk("grants_outstanding", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
